// File: rtl/fetch_queue.sv
// Instruction fetch front end: pipelined imem word requests feed an in-order (instr, pc) prefetch FIFO.
// Latency: imem_rvalid -> out_valid one cycle. Backpressure: issue stops once FIFO + in-flight reaches DEPTH.

module fetch_queue_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   wr_vld,
  input  logic [DW-1:0]          wr_dat,
  output logic                   rd_vld,
  input  logic                   rd_rdy,
  output logic [DW-1:0]          rd_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_wr, do_rd;

  // Flush wins over any same-cycle write or read.
  assign do_wr  = wr_vld && !flush;
  assign do_rd  = rd_vld && rd_rdy && !flush;
  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_wr) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      count <= count + CW'(1);
      else if (!do_wr && do_rd) count <= count - CW'(1);
    end
  end
endmodule

module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  output logic                   out_valid,
  output logic [31:0]            out_instr,
  output logic [XLEN-1:0]        out_pc,
  input  logic                   out_ready,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0] count
);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(DEPTH) + 2;

  logic [XLEN-1:0]    fetch_pc, rsp_pc, target_pc;
  logic [OW-1:0]      outstanding, discard;
  logic [SW-1:0]      occupancy;
  logic               grant, push;
  logic [32+XLEN-1:0] head;

  assign target_pc = redirect_pc & ~XLEN'(3);
  assign occupancy = SW'(count) + SW'(outstanding);
  assign imem_req  = !reset && !redirect && (occupancy < SW'(DEPTH)) && (outstanding < OW'(MAX_OUT));
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;
  assign push      = imem_rvalid && (discard == '0) && !redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (grant && !imem_rvalid)      outstanding <= outstanding + OW'(1);
      else if (!grant && imem_rvalid) outstanding <= outstanding - OW'(1);
      // outstanding already counts words still owed to discard, so after a
      // redirect every word in flight beyond this cycle's response is stale.
      if (redirect)                           discard <= outstanding - OW'(imem_rvalid);
      else if (imem_rvalid && discard != '0)  discard <= discard - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= target_pc;
      rsp_pc   <= target_pc;
    end else begin
      if (grant) fetch_pc <= fetch_pc + XLEN'(4);
      if (push)  rsp_pc   <= rsp_pc + XLEN'(4);
    end
  end

  fetch_queue_fifo #(
    .DW    (32 + XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (reset),
    .flush  (redirect),
    .wr_vld (push),
    .wr_dat ({imem_rdata, rsp_pc}),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (head),
    .count  (count)
  );

  assign out_instr = head[XLEN +: 32];
  assign out_pc    = head[XLEN-1:0];
endmodule
